// File: rtl/fpga_operand_entry.sv
// fpga_operand_entry: board-input front end for the DE2 ALU bring-up.
// This block synchronizes the raw KEY and SW inputs and debounces the enter
// and cancel pushbuttons. The user keys in operand A, operand B and the ALU
// opcode one after another. The completed set is then offered to the ALU
// harness over a valid/ready handshake.
module fpga_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,  // stable-level cycles to accept a key change, >= 2
    parameter int SYNC_STAGES     = 2        // synchronizer depth on every raw input, >= 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [3:0]  KEY,       // active-low; [0] enter, [1] cancel, [3:2] unused
    input  logic [17:0] SW,        // [15:0] value, [16] sign fill, [3:0] opcode
    output logic [31:0] porta,
    output logic [31:0] portb,
    output logic [3:0]  aluop,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  stage
);

    // Entry states; the encoding is shown directly on LEDG.
    localparam logic [1:0] GET_A  = 2'd0;
    localparam logic [1:0] GET_B  = 2'd1;
    localparam logic [1:0] GET_OP = 2'd2;
    localparam logic [1:0] ISSUE  = 2'd3;

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int KEY_ENTER  = 0;
    localparam int KEY_CANCEL = 1;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [3:0]  key_sync_q [SYNC_STAGES];
    logic [17:0] sw_sync_q  [SYNC_STAGES];
    logic [3:0]  key_s;
    logic [17:0] sw_s;

    // Shift raw KEY/SW through SYNC_STAGES flops to resolve metastability.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            // NOTE: the synchronizer array is small flop storage, not RAM.
            // Every stage is reset. KEY stages reset to released (1) so that
            // reset deassert cannot be taken for a key press.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                key_sync_q[i] <= '1;
                sw_sync_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of the stage before it. Blocking assignments here would
            // collapse the chain into one flop.
            key_sync_q[0] <= KEY;
            sw_sync_q[0]  <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                key_sync_q[i] <= key_sync_q[i-1];
                sw_sync_q[i]  <= sw_sync_q[i-1];
            end
        end
    end

    assign key_s = key_sync_q[SYNC_STAGES-1];
    assign sw_s  = sw_sync_q[SYNC_STAGES-1];

    // KEY[3:2] and SW[17] are synchronized like the other inputs, but no logic reads them.
    logic unused_sync;
    assign unused_sync = ^{key_s[3:2], sw_s[17]};

    // ------------------------------------------------------------------
    // Debounce and press-event generation for enter and cancel
    // ------------------------------------------------------------------
    logic [1:0]       stable_q;        // accepted (debounced) key level, 1 = released
    logic [CNT_W-1:0] cnt_q [2];       // cycles the synchronized level has disagreed
    logic [1:0]       press_q;         // one-cycle pulse on accepted 1->0 transition

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            stable_q <= 2'b11;
            press_q  <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                press_q[k] <= 1'b0;
                if (key_s[k] == stable_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == CNT_MAX) begin
                    stable_q[k] <= key_s[k];
                    cnt_q[k]    <= '0;
                    // Only a press (released -> pressed) is an event.
                    press_q[k]  <= ~key_s[k];
                end else begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    logic enter_evt;
    logic cancel_evt;
    assign enter_evt  = press_q[KEY_ENTER];
    assign cancel_evt = press_q[KEY_CANCEL];

    // ------------------------------------------------------------------
    // Entry FSM and captured operand registers
    // ------------------------------------------------------------------
    logic [1:0]  state_q,    state_d;
    logic [31:0] porta_q,    porta_d;
    logic [31:0] portb_q,    portb_d;
    logic [3:0]  aluop_q,    aluop_d;
    logic        op_valid_q, op_valid_d;
    logic [31:0] value;

    // SW[15:0] sign-extended using SW[16] as the fill bit.
    assign value = {{16{sw_s[16]}}, sw_s[15:0]};

    // Next state and capture decisions; cancel overrides every other event.
    always_comb begin
        // NOTE: every variable gets its hold value first. This way a path
        // through the case that leaves a variable unassigned keeps the
        // register value and cannot infer a latch.
        state_d = state_q;
        porta_d = porta_q;
        portb_d = portb_q;
        aluop_d = aluop_q;

        if (cancel_evt) begin
            state_d = GET_A;
            porta_d = '0;
            portb_d = '0;
            aluop_d = '0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (enter_evt) begin
                        porta_d = value;
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (enter_evt) begin
                        portb_d = value;
                        state_d = GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter_evt) begin
                        aluop_d = sw_s[3:0];
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    // Operands are frozen and enter is ignored. The only
                    // exits are a completed transfer or a cancel.
                    if (op_valid_q && op_ready) begin
                        state_d = GET_A;
                    end
                end
                default: state_d = GET_A;
            endcase
        end

        // A registered op_valid that mirrors the ISSUE state exactly.
        op_valid_d = (state_d == ISSUE);
    end

    // State and captured-operand registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= GET_A;
            porta_q    <= '0;
            portb_q    <= '0;
            aluop_q    <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            porta_q    <= porta_d;
            portb_q    <= portb_d;
            aluop_q    <= aluop_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign porta    = porta_q;
    assign portb    = portb_q;
    assign aluop    = aluop_q;
    assign op_valid = op_valid_q;
    assign stage    = state_q;

endmodule

// File: tb/tb_fpga_operand_entry.sv
// tb_fpga_operand_entry: directed bench for fpga_operand_entry, built with
// DEBOUNCE_CYCLES=4 and SYNC_STAGES=2. A vector table walks the entry flow.
// Hand-written sequences then cover bounce, latency, hold, backpressure,
// cancel against a transfer, and async reset.
module tb_fpga_operand_entry;

    logic        clk;
    logic        RESET;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [31:0] porta;
    logic [31:0] portb;
    logic [3:0]  aluop;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  stage;

    int total = 0;
    int bad   = 0;

    fpga_operand_entry #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (RESET),
        .KEY     (KEY),
        .SW      (SW),
        .porta   (porta),
        .portb   (portb),
        .aluop   (aluop),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .stage   (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [1:0] {ACT_ENTER, ACT_CANCEL, ACT_BOTH, ACT_READY} act_e;

    typedef struct {
        act_e        act;
        logic [17:0] sw;
        logic [1:0]  st;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        v;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] st, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] op, input logic v);
        check({name, ".stage"},    {30'd0, stage}, {30'd0, st});
        check({name, ".porta"},    porta, a);
        check({name, ".portb"},    portb, b);
        check({name, ".aluop"},    {28'd0, aluop}, {28'd0, op});
        check({name, ".op_valid"}, {31'd0, op_valid}, {31'd0, v});
    endtask

    // keys[0] = enter, keys[1] = cancel; held 10 cycles, then released for 10 cycles.
    task automatic press(input logic [1:0] keys, input logic [17:0] sw_val);
        @(posedge clk); #1;
        SW       = sw_val;
        KEY[1:0] = ~keys;
        repeat (10) @(posedge clk);
        #1 KEY[1:0] = 2'b11;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic ready_pulse();
        @(posedge clk); #1 op_ready = 1'b1;
        @(posedge clk); #1 op_ready = 1'b0;
    endtask

    initial begin
        RESET    = 1'b1;
        KEY      = 4'hF;
        SW       = '0;
        op_ready = 1'b0;

        vecs[0]  = '{ACT_ENTER,  18'h00005, 2'd1, 32'h00000005, 32'h00000000, 4'h0, 1'b0};
        vecs[1]  = '{ACT_ENTER,  18'h1FFFE, 2'd2, 32'h00000005, 32'hFFFFFFFE, 4'h0, 1'b0};
        vecs[2]  = '{ACT_ENTER,  18'h00003, 2'd3, 32'h00000005, 32'hFFFFFFFE, 4'h3, 1'b1};
        vecs[3]  = '{ACT_READY,  18'h00003, 2'd0, 32'h00000005, 32'hFFFFFFFE, 4'h3, 1'b0};
        vecs[4]  = '{ACT_ENTER,  18'h01234, 2'd1, 32'h00001234, 32'hFFFFFFFE, 4'h3, 1'b0};
        vecs[5]  = '{ACT_ENTER,  18'h18000, 2'd2, 32'h00001234, 32'hFFFF8000, 4'h3, 1'b0};
        vecs[6]  = '{ACT_CANCEL, 18'h18000, 2'd0, 32'h00000000, 32'h00000000, 4'h0, 1'b0};
        vecs[7]  = '{ACT_ENTER,  18'h20007, 2'd1, 32'h00000007, 32'h00000000, 4'h0, 1'b0};
        vecs[8]  = '{ACT_BOTH,   18'h000AA, 2'd0, 32'h00000000, 32'h00000000, 4'h0, 1'b0};
        vecs[9]  = '{ACT_ENTER,  18'h07FFF, 2'd1, 32'h00007FFF, 32'h00000000, 4'h0, 1'b0};
        vecs[10] = '{ACT_READY,  18'h07FFF, 2'd1, 32'h00007FFF, 32'h00000000, 4'h0, 1'b0};
        vecs[11] = '{ACT_ENTER,  18'h10000, 2'd2, 32'h00007FFF, 32'hFFFF0000, 4'h0, 1'b0};
        vecs[12] = '{ACT_ENTER,  18'h3FFFC, 2'd3, 32'h00007FFF, 32'hFFFF0000, 4'hC, 1'b1};
        vecs[13] = '{ACT_ENTER,  18'h00001, 2'd3, 32'h00007FFF, 32'hFFFF0000, 4'hC, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
        RESET = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Table-driven entry flow.
        for (int i = 0; i < 14; i++) begin
            case (vecs[i].act)
                ACT_ENTER:  press(2'b01, vecs[i].sw);
                ACT_CANCEL: press(2'b10, vecs[i].sw);
                ACT_BOTH:   press(2'b11, vecs[i].sw);
                default:    ready_pulse();
            endcase
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].v);
        end

        // Cancel in ISSUE in the same cycle as op_ready: cancel wins and clears operands.
        @(posedge clk); #1 KEY[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("cxr.before", {30'd0, stage}, 32'd3);
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        check_all("cxr", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
        KEY[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Bounce: five 3-cycle glitches, then a steady press with fixed latency.
        SW = 18'h00042;
        for (int n = 0; n < 5; n++) begin
            KEY[0] = 1'b0;
            repeat (3) @(posedge clk);
            #1 KEY[0] = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
        check("bounce.glitch", {30'd0, stage}, 32'd0);
        KEY[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("bounce.early", {30'd0, stage}, 32'd0);
        @(posedge clk); #1;
        check("bounce.latency", {30'd0, stage}, 32'd1);
        repeat (3) @(posedge clk);
        #1 KEY[0] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("bounce.stage", {30'd0, stage}, 32'd1);
        check("bounce.porta", porta, 32'h00000042);

        // Held key: 100 cycles low in GET_A advances exactly once.
        press(2'b10, 18'h00000);
        SW     = 18'h00099;
        KEY[0] = 1'b0;
        repeat (100) @(posedge clk);
        #1 KEY[0] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("hold.stage", {30'd0, stage}, 32'd1);
        check("hold.porta", porta, 32'h00000099);

        // Backpressure: ISSUE holds steady while SW toggles and enter is pressed.
        press(2'b01, 18'h00010);
        press(2'b01, 18'h00005);
        check_all("issue", 2'd3, 32'h99, 32'h10, 4'h5, 1'b1);
        press(2'b01, 18'h3ABCD);
        press(2'b01, 18'h15A5A);
        press(2'b01, 18'h0000F);
        check_all("bp", 2'd3, 32'h99, 32'h10, 4'h5, 1'b1);
        ready_pulse();
        check_all("bp.xfer", 2'd0, 32'h99, 32'h10, 4'h5, 1'b0);

        // Async reset mid-cycle in ISSUE: outputs clear without a clock edge.
        press(2'b01, 18'h00001);
        press(2'b01, 18'h00002);
        press(2'b01, 18'h00007);
        check("pre_rst.stage", {30'd0, stage}, 32'd3);
        @(posedge clk);
        #3 RESET = 1'b1;
        #1;
        check_all("async_rst", 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Enter held through reset deassert is seen as a fresh press.
        KEY[0] = 1'b0;
        SW     = 18'h00033;
        @(posedge clk); #1 RESET = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("held_rst.stage", {30'd0, stage}, 32'd1);
        check("held_rst.porta", porta, 32'h00000033);
        KEY[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("held_rst.final", {30'd0, stage}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
